// File: rtl/inst_fetch_buffer_pkg.sv
// inst_fetch_buffer_pkg: shared types and constants for the fetch front end
package inst_fetch_buffer_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  localparam int MAX_PID_W = 8;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [31:0]          inst;
    logic [31:0]          addr;
    logic [MAX_PID_W-1:0] pid;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous first-word-fall-through FIFO with wrap-around pointers
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: fetch PC/request FSM feeding a tagged instruction queue
module inst_fetch_buffer import inst_fetch_buffer_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          PID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     jumpFlag_i,
  input  logic [31:0]              jumpAddr_i,
  output logic                     request_o,
  output logic [31:0]              instAddr_fetch_o,
  input  logic                     dataOk_i,
  input  logic [31:0]              inst_fetch_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [31:0]              inst_o,
  output logic [31:0]              instAddr_o,
  output logic [PID_W-1:0]         pID_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 64 + PID_W;
  state_t           state, state_d;
  logic [31:0]      fetch_pc, drop_addr;
  logic [PID_W-1:0] pid;
  logic             push, pop, room;
  logic [CW-1:0]    count, cnt_nx;
  logic [EW-1:0]    din, head;
  assign valid_o          = count != '0;
  assign count_o          = count;
  assign pop              = valid_o && ready_i && !jumpFlag_i;
  assign push             = state == REQ && dataOk_i && !jumpFlag_i;
  assign cnt_nx           = count + CW'(push) - CW'(pop);
  assign room             = cnt_nx < CW'(DEPTH);
  assign din              = {inst_fetch_i, fetch_pc, pid};
  assign instAddr_fetch_o = state == DROP ? drop_addr : fetch_pc;
  assign inst_o           = valid_o ? head[EW-1 -: 32] : '0;
  assign instAddr_o       = valid_o ? head[PID_W +: 32] : '0;
  assign pID_o            = valid_o ? head[PID_W-1:0] : '0;
  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (jumpFlag_i),
    .din   (din),
    .head  (head),
    .count (count)
  );
  always_comb begin
    state_d   = state;
    request_o = state != IDLE;
    if (jumpFlag_i)
      state_d = (state != IDLE && !dataOk_i) ? DROP : REQ;
    else if (state == IDLE || (state == REQ && dataOk_i))
      state_d = room ? REQ : IDLE;
    else if (state == DROP && dataOk_i)
      state_d = REQ;
  end
  // A redirect mid-request keeps presenting the old address until memory answers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
      pid       <= '0;
    end else begin
      state <= state_d;
      if (jumpFlag_i) begin
        fetch_pc <= jumpAddr_i;
        pid      <= '0;
        if (state == REQ) drop_addr <= fetch_pc;
      end else if (push) begin
        fetch_pc <= fetch_pc + PC_INC;
        pid      <= pid + PID_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed stimulus with a queue-based reference model
module tb_inst_fetch_buffer;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 1, jumpFlag_i = 0, dataOk_i = 0, ready_i = 0;
  logic [31:0] jumpAddr_i = 0, inst_fetch_i = 0;
  logic        request_o, valid_o;
  logic [31:0] instAddr_fetch_o, inst_o, instAddr_o;
  logic [1:0]  pID_o;
  logic [2:0]  count_o;

  inst_fetch_buffer #(.RESET_PC(32'h0), .DEPTH(DEPTH), .PID_W(2)) dut (
    .clk(clk), .reset(reset), .jumpFlag_i(jumpFlag_i), .jumpAddr_i(jumpAddr_i),
    .request_o(request_o), .instAddr_fetch_o(instAddr_fetch_o), .dataOk_i(dataOk_i),
    .inst_fetch_i(inst_fetch_i), .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o),
    .instAddr_o(instAddr_o), .pID_o(pID_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  int lat = 0, age = 0;
  logic req_prev = 0;

  typedef struct {logic [31:0] inst; logic [31:0] addr; logic [1:0] pid;} ent_t;
  ent_t mq[$], acc[$];
  logic        m_req = 0, m_drop = 0;
  logic [31:0] m_pc = 0, m_raddr = 0;
  logic [1:0]  m_pid = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
  endtask

  task automatic chk_acc(input string n, input int i, input logic [31:0] addr, input logic [1:0] pid);
    chk({n, "_present"}, 32'(acc.size() > i), 1);
    if (acc.size() > i) begin
      chk({n, "_addr"}, acc[i].addr, addr);
      chk({n, "_pid"}, 32'(acc[i].pid), 32'(pid));
      chk({n, "_inst"}, acc[i].inst, mem_word(addr));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: answers a request after lat cycles (lat=0 answers in the request cycle)
  always @(posedge clk) begin
    #1;
    age = (request_o && req_prev && !dataOk_i) ? age + 1 : 0;
    req_prev = request_o;
    dataOk_i = request_o && age >= lat;
    inst_fetch_i = mem_word(instAddr_fetch_o);
  end

  // Reference: a request is pending whenever the queue has room; redirect discards everything
  always @(posedge clk) begin
    if (reset) begin
      mq.delete(); m_pc = 0; m_pid = 0; m_req = 0; m_drop = 0; m_raddr = 0;
    end else if (jumpFlag_i) begin
      mq.delete(); m_pc = jumpAddr_i; m_pid = 0;
      if (m_req && !dataOk_i) m_drop = 1;
      else begin m_drop = 0; m_req = 1; m_raddr = m_pc; end
    end else begin
      if (mq.size() != 0 && ready_i) mq.delete(0);
      if (m_req && dataOk_i) begin
        if (m_drop) m_drop = 0;
        else begin
          mq.push_back('{inst: inst_fetch_i, addr: m_pc, pid: m_pid});
          m_pc = m_pc + 4; m_pid = m_pid + 2'd1;
        end
        m_req = mq.size() < DEPTH; m_raddr = m_pc;
      end else if (!m_req) begin
        m_req = mq.size() < DEPTH; m_raddr = m_pc;
      end
    end
  end

  always @(negedge clk) begin
    chk("request", 32'(request_o), 32'(m_req));
    if (m_req) chk("fetch_addr", instAddr_fetch_o, m_raddr);
    chk("valid", 32'(valid_o), 32'(mq.size() != 0));
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("inst", inst_o, mq.size() != 0 ? mq[0].inst : 32'h0);
    chk("inst_addr", instAddr_o, mq.size() != 0 ? mq[0].addr : 32'h0);
    chk("pid", 32'(pID_o), mq.size() != 0 ? 32'(mq[0].pid) : 32'h0);
    if (mq.size() != 0 && ready_i && !jumpFlag_i && !reset) acc.push_back(mq[0]);
  end

  task automatic do_reset();
    reset = 1; jumpFlag_i = 0;
    tick(); tick();
  endtask

  initial begin
    reset = 1; ready_i = 0; lat = 2;
    tick(); tick();
    chk("rst_request", 32'(request_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_inst", inst_o, 0);

    // In-order delivery with a 2-cycle memory
    ready_i = 1; reset = 0; acc.delete();
    tick();
    chk("t1_first_req", 32'(request_o), 1);
    chk("t1_first_addr", instAddr_fetch_o, 32'h0);
    repeat (12) tick();
    chk_acc("t1_e0", 0, 32'h0, 2'd0);
    chk_acc("t1_e1", 1, 32'h4, 2'd1);
    chk_acc("t1_e2", 2, 32'h8, 2'd2);

    // Fill with decoder stalled, then one pop re-opens fetching
    do_reset(); ready_i = 0; lat = 0; reset = 0;
    tick();
    repeat (6) tick();
    chk("t2_full_count", 32'(count_o), 4);
    chk("t2_full_req", 32'(request_o), 0);
    ready_i = 1;
    tick();
    ready_i = 0;
    chk("t2_pop_count", 32'(count_o), 3);
    chk("t2_rereq", 32'(request_o), 1);
    chk("t2_rereq_addr", instAddr_fetch_o, 32'h10);
    chk("t2_head_addr", instAddr_o, 32'h4);

    // Tag wrap
    do_reset(); ready_i = 1; lat = 0; reset = 0; acc.delete();
    repeat (10) tick();
    chk_acc("t3_e3", 3, 32'hC, 2'd3);
    chk_acc("t3_e4", 4, 32'h10, 2'd0);
    chk_acc("t3_e5", 5, 32'h14, 2'd1);

    // Redirect while a request is outstanding
    do_reset(); ready_i = 1; lat = 3; reset = 0;
    for (int i = 0; i < 60 && !(request_o && instAddr_fetch_o == 32'h8); i++) tick();
    chk("t4_wait_req8", 32'(request_o && instAddr_fetch_o == 32'h8), 1);
    jumpFlag_i = 1; jumpAddr_i = 32'h100; acc.delete();
    tick();
    jumpFlag_i = 0;
    chk("t4_valid", 32'(valid_o), 0);
    chk("t4_drop_req", 32'(request_o), 1);
    chk("t4_drop_addr", instAddr_fetch_o, 32'h8);
    tick(); tick();
    chk("t4_drop_addr_late", instAddr_fetch_o, 32'h8);
    tick();
    chk("t4_new_addr", instAddr_fetch_o, 32'h100);
    repeat (12) tick();
    chk_acc("t4_e0", 0, 32'h100, 2'd0);
    chk_acc("t4_e1", 1, 32'h104, 2'd1);

    // Redirect coinciding with dataOk and a pop
    do_reset(); ready_i = 0; lat = 0; reset = 0;
    for (int i = 0; i < 20 && count_o != 3'd2; i++) tick();
    chk("t5_wait_cnt2", 32'(count_o), 2);
    ready_i = 1; jumpFlag_i = 1; jumpAddr_i = 32'h200;
    tick();
    jumpFlag_i = 0; ready_i = 0;
    chk("t5_count", 32'(count_o), 0);
    chk("t5_valid", 32'(valid_o), 0);
    chk("t5_req", 32'(request_o), 1);
    chk("t5_addr", instAddr_fetch_o, 32'h200);

    // Reset mid-request with entries queued
    do_reset(); ready_i = 0; lat = 0; reset = 0;
    for (int i = 0; i < 20 && count_o != 3'd3; i++) tick();
    chk("t6_wait_cnt3", 32'(count_o), 3);
    reset = 1;
    tick();
    chk("t6_count", 32'(count_o), 0);
    chk("t6_valid", 32'(valid_o), 0);
    chk("t6_req", 32'(request_o), 0);
    reset = 0;
    tick();
    chk("t6_restart_req", 32'(request_o), 1);
    chk("t6_restart_addr", instAddr_fetch_o, 32'h0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
